uart_tx_fifo: RTL
=================

# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the host through a write strobe, stores up to DEPTH entries, and launches them into the transmitter one at a time. Launches use the transmitter's start pulse, data bus and busy flag. It decouples bursty producers from the serial line rate so the host never waits on `busy`.

## Interface
- `DATA_BITS`, 8, width of one character; must match the transmitter.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `BUSY_WAIT`, 4, cycles after `tx_start` to wait for `tx_busy` rise before abandoning the wait.

- `clk` input 1, clock of the transmitter's start/busy interface.
- `reset` input 1, synchronous, active-high.
- `wr_en` input 1, push `wr_data` this cycle.
- `wr_data` input DATA_BITS, byte to enqueue.
- `full` output 1, no free entry.
- `empty` output 1, no stored entry.
- `count` output $clog2(DEPTH)+1, entries currently stored.
- `overflow` output 1, sticky: a write was dropped.
- `tx_start` output 1, one-cycle launch pulse to the transmitter.
- `tx_data` output DATA_BITS, byte presented with and held after `tx_start`.
- `tx_busy` input 1, transmitter busy flag.

## Operation
- Storage is a circular buffer with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap DEPTH-1→0, plus a registered `count`.
- `full` = (count == DEPTH); `empty` = (count == 0). Both are registered and consistent with `count`.
- Write: if `wr_en` && !`full`, store at `wr_ptr` and increment the pointer. If `wr_en` && `full`, drop the write; pointers and data are unchanged.
- A write while `full` is dropped even if a pop occurs in the same cycle.
- The launch FSM has four states:
  - IDLE: if !`empty` && !`tx_busy`, pop. Load `tx_data` from `rd_ptr`, advance `rd_ptr`, then go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy`=1, go to WAIT_DONE. After BUSY_WAIT cycles without a rise, return to IDLE; the byte counts as consumed.
  - WAIT_DONE: on `tx_busy`=0, go to IDLE.
- A simultaneous push and pop leaves `count` unchanged; both pointers advance.
- `tx_data` holds its value until the next pop.

## Timing
- Reset values: state IDLE, pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0, `tx_start` 0, `tx_data` 0.
- Reset has priority over all activity. A reset mid-transfer discards all stored bytes and drops `tx_start` the same edge; the transmitter shares `reset`.
- Write at edge N into an empty FIFO: `count`=1 and `empty`=0 after N. Pop occurs at N+1 and `tx_start` is high during cycle N+2.
- Back-to-back bytes: the next pop occurs on the first IDLE cycle after `tx_busy` falls. The minimum gap between `tx_start` pulses is 4 cycles plus the busy duration.
- `tx_start` is never asserted while `tx_busy`=1 was sampled high in the pop cycle.
- `count`, `full` and `empty` update one edge after the causing write or pop.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined: `overflow` is set on the first dropped write and held until `reset`.
- `UART_TX_FIFO_OVF_EN` undefined: `overflow` is tied to 0 and no overflow logic is built.
- Port list is identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - the launch-state enum `tx_fifo_state_t` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - the pointer/count width helper constants.
- One sub-module, `uart_fifo_mem`: a DEPTH×DATA_BITS register array with one synchronous write port and one asynchronous read port, reset-free.
- Pointers, count, flags and FSM live in `uart_tx_fifo`.

## Test plan
- Reset, then write 0xA5 with `tx_busy` held 0 until `tx_start`, then `tx_busy` high 10 cycles → one `tx_start` pulse at write+2 with `tx_data`=0xA5; `count` returns to 0 and the FSM ends in IDLE.
- Write 16 bytes 0x00..0x0F back-to-back with `tx_busy` stuck 1 → `full`=1, `count`=16, no `tx_start`. Release busy → bytes launch in order 0x00..0x0F, with exactly one pulse per busy low phase.
- With FIFO full, write 0xFF → byte dropped, `count` stays 16; `overflow`=1 if `UART_TX_FIFO_OVF_EN`, else 0. The 0xFF byte is never transmitted.
- Push while a pop occurs at count=5 → `count` stays 5 and the pointers wrap correctly across the 15→0 boundary over 40 random pushes/pops against a scoreboard.
- After `tx_start`, hold `tx_busy`=0 → FSM returns to IDLE after 4 cycles and the next byte launches.
- Assert `reset` in WAIT_DONE with 3 bytes queued → next cycle `count`=0, `empty`=1, `tx_start`=0, `overflow`=0, state IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and width helpers for the UART transmit FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_t;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_BUSY_WAIT = 4;

  // Never returns 0 so a depth/limit of 1 still yields a legal vector.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : DEPTH x DATA_BITS register array, one synchronous write port
//                and one asynchronous read port, no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_BITS-1:0]     wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_BITS-1:0]     rdata_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Transmit byte FIFO feeding a UART transmitter via start/busy.
//                Optional macro UART_TX_FIFO_OVF_EN builds the sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned BUSY_WAIT = DEF_BUSY_WAIT
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [DATA_BITS-1:0]   wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   tx_start_o,
  output logic [DATA_BITS-1:0]   tx_data_o,
  input  logic                   tx_busy_i
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned WAIT_W = ptr_width(BUSY_WAIT);

  localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  tx_fifo_state_t       state_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, empty_q;
  logic                 tx_start_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic [WAIT_W-1:0]    wait_q;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 push, pop;

  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign push = wr_en_i && !full_q;
  assign pop  = (state_q == IDLE) && !empty_q && !tx_busy_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  uart_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wait_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      count_q    <= count_d;
      full_q     <= (count_d == C_DEPTH);
      empty_q    <= (count_d == '0);
      tx_start_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_rdata;
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_q  <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never raises busy must not stall the queue.
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (wait_q == C_WAIT_LAST) begin
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
    end else if (wr_en_i && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule

`default_nettype wire
